hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU (IF/ID/EX/MEM/WB).
- Detects load-use hazards and stalls IF/ID.
- Generates EX operand forwarding selects.
- Squashes wrong-path instructions on jumps and taken branches.
- Sequences the syscall/zero-instruction halt: drains in-flight instructions, then freezes the pipeline.
- Sits beside ID; drives the pipeline-register enables and flushes and the EX forwarding muxes.

Parameters:
- DRAIN_CYCLES, 3: cycles spent in DRAIN before HALTED (EX, MEM, WB retire).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs_id, rt_id  in  5 each  ID source register numbers.
- use_rs_id, use_rt_id  in  1 each  ID instruction reads rs / rt.
- jump_id  in  1  j/jal/jr decoded in ID.
- halt_id  in  1  halt condition decoded in ID.
- rs_ex, rt_ex  in  5 each  EX source register numbers.
- rw_ex  in  5  EX destination register.
- regwrite_ex, memtoreg_ex  in  1 each  EX write-enable / load flag.
- branch_taken_ex  in  1  branch resolved taken in EX.
- rw_mem, regwrite_mem  in  5, 1  MEM destination register / write-enable.
- rw_wb, regwrite_wb  in  5, 1  WB destination register / write-enable.
- pc_en  out  1  PC register update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID register becomes a bubble.
- idex_flush  out  1  ID/EX register becomes a bubble.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 = register file, 01 = MEM ALU result, 10 = WB write data.
- halted  out  1  pipeline frozen.
- stall_cnt, flush_cnt, cycle_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=RUN, drain counter=0, halted=0, all counters 0.
  - While reset is held: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1.
- Forwarding (combinational, active in all states):
  - fwd_a=01 if regwrite_mem && rw_mem!=0 && rw_mem==rs_ex.
  - Otherwise fwd_a=10 if regwrite_wb && rw_wb!=0 && rw_wb==rs_ex.
  - Otherwise fwd_a=00.
  - fwd_b: identical rule using rt_ex.
  - MEM has priority over WB; register 0 is never forwarded.
- Load-use hazard (lu):
  - lu = regwrite_ex && memtoreg_ex && rw_ex!=0 && ((use_rs_id && rw_ex==rs_id) || (use_rt_id && rw_ex==rt_id)).
- RUN state, outputs by priority (highest first):
  1. branch_taken_ex: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. Squashes 2 instructions; overrides lu, jump_id and halt_id.
  2. lu: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0. Exactly one bubble; the load advances to MEM, so lu clears next cycle.
  3. halt_id: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=0. Halting instruction proceeds; go to DRAIN, drain counter=0.
  4. jump_id: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=0.
  5. Otherwise: pc_en=1, ifid_en=1, both flushes 0.
  - lu together with halt_id: stall takes effect, halt is evaluated again the next cycle.
- DRAIN state:
  - pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1; the drain counter increments each cycle.
  - When drain counter==DRAIN_CYCLES-1, go to HALTED.
  - branch_taken_ex is ignored in DRAIN: instructions older than the halt cannot be branches resolving after it, because the halt was taken only when no branch was in EX.
- HALTED state:
  - halted=1; pc_en=0, ifid_en=0, both flushes 1.
  - Left only by reset.
- Counters (wrap at 2^CNT_W):
  - cycle_cnt increments every cycle outside HALTED.
  - stall_cnt increments on every RUN cycle with lu as the winning condition.
  - flush_cnt increments on every RUN cycle with branch_taken_ex or jump_id as the winning condition.
- Reset asserted mid-DRAIN: returns to RUN immediately; the drain counter clears.

Optional Feature:
- HAZARD_PERF_EN defined: the three counters are implemented as above.
- HAZARD_PERF_EN undefined: no counter flops; stall_cnt, flush_cnt and cycle_cnt are tied to 0. Ports remain.

Decomposition:
- Shared package holds:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - State encoding RUN=2'd0, DRAIN=2'd1, HALTED=2'd2.
  - REG_ZERO=5'd0.
- One sub-module, hazard_fwd_unit: purely combinational forwarding compare for one operand, instantiated twice (rs_ex, rt_ex).
- FSM, stall/flush priority logic and counters live in hazard_ctrl.

Test Plan:
- Forwarding priority: regwrite_mem=1, rw_mem=8; regwrite_wb=1, rw_wb=8; rs_ex=8 -> fwd_a=01. Same with regwrite_mem=0 -> fwd_a=10. rs_ex=0 with rw_mem=0 -> fwd_a=00.
- Load-use: EX load rw_ex=5 (memtoreg_ex=1, regwrite_ex=1); ID rs_id=5, use_rs_id=1 -> exactly 1 cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1. Next cycle (EX idle) -> pc_en=1.
- Branch over load-use: branch_taken_ex=1 with lu=1 and jump_id=1 -> ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt +1; stall_cnt unchanged.
- Halt sequence: halt_id=1 for one cycle in RUN -> pc_en=0 from that cycle; DRAIN for 3 cycles; halted=1 on the 4th cycle and stays 1 for 20 more cycles; cycle_cnt frozen.
- Branch cancels halt: halt_id=1 and branch_taken_ex=1 together -> state stays RUN, halted stays 0, both flushes 1.
- Asynchronous reset: rst_n pulled low mid-DRAIN (not aligned to clk) -> halted=0 and counters 0 immediately. After rst_n rises: pc_en=1, state RUN.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared constants for the pipeline hazard controller:
//   - forwarding select codes driven onto the EX operand muxes
//   - FSM state encoding (RUN / DRAIN / HALTED)
//   - the hard-wired zero register number
//   - a packed bundle of the four pipeline-register control bits
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] DRAIN   = 2'd1;
    localparam logic [1:0] HALTED  = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_flush;
    } pipe_ctl_t;

    // A later stage produces a value the EX operand needs; r0 is never forwarded.
    function automatic logic reg_hit(input logic       we,
                                     input logic [4:0] rd,
                                     input logic [4:0] src);
        return we && (rd != REG_ZERO) && (rd == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// Combinational forwarding select for one EX operand. MEM has priority over
// WB because it holds the younger result.
// Ports:
//   src_reg       in  5  EX source register number
//   rw_mem        in  5  MEM destination register
//   regwrite_mem  in  1  MEM write-enable
//   rw_wb         in  5  WB destination register
//   regwrite_wb   in  1  WB write-enable
//   fwd_sel       out 2  00 = register file, 01 = MEM result, 10 = WB data
module hazard_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_reg,
    input  logic [4:0] rw_mem,
    input  logic       regwrite_mem,
    input  logic [4:0] rw_wb,
    input  logic       regwrite_wb,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_hit(regwrite_mem, rw_mem, src_reg)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_hit(regwrite_wb, rw_wb, src_reg)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage CPU. Sits beside ID and
// drives the PC / IF/ID enables, the IF/ID and ID/EX flushes and the EX
// forwarding selects. Handles load-use stalls, jump / taken-branch squashes
// and the halt sequence (drain in-flight instructions, then freeze).
//
// Build option: define HAZARD_PERF_EN to implement the stall / flush / cycle
// performance counters; otherwise the counter ports are tied to zero.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   rs_id, rt_id, use_rs_id,
//   use_rt_id, jump_id, halt_id   ID-stage decode information
//   rs_ex, rt_ex, rw_ex,
//   regwrite_ex, memtoreg_ex,
//   branch_taken_ex               EX-stage information
//   rw_mem, regwrite_mem          MEM destination
//   rw_wb, regwrite_wb            WB destination
//   pc_en, ifid_en                register enables
//   ifid_flush, idex_flush        bubble insertion
//   fwd_a, fwd_b                  EX operand forwarding selects
//   halted                        pipeline frozen
//   stall_cnt, flush_cnt,
//   cycle_cnt                     performance counters
//
// state  | meaning
// RUN    | normal issue; stall / squash / halt decisions by priority
// DRAIN  | halt accepted, fetch frozen while EX/MEM/WB retire
// HALTED | pipeline frozen until reset
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic             jump_id,
    input  logic             halt_id,
    input  logic [4:0]       rs_ex,
    input  logic [4:0]       rt_ex,
    input  logic [4:0]       rw_ex,
    input  logic             regwrite_ex,
    input  logic             memtoreg_ex,
    input  logic             branch_taken_ex,
    input  logic [4:0]       rw_mem,
    input  logic             regwrite_mem,
    input  logic [4:0]       rw_wb,
    input  logic             regwrite_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    logic [1:0]    state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic          lu;
    pipe_ctl_t     ctl;

    hazard_fwd_unit u_fwd_a (
        .src_reg      (rs_ex),
        .rw_mem       (rw_mem),
        .regwrite_mem (regwrite_mem),
        .rw_wb        (rw_wb),
        .regwrite_wb  (regwrite_wb),
        .fwd_sel      (fwd_a)
    );

    hazard_fwd_unit u_fwd_b (
        .src_reg      (rt_ex),
        .rw_mem       (rw_mem),
        .regwrite_mem (regwrite_mem),
        .rw_wb        (rw_wb),
        .regwrite_wb  (regwrite_wb),
        .fwd_sel      (fwd_b)
    );

    // Load in EX whose result an ID operand actually reads.
    assign lu = regwrite_ex && memtoreg_ex && (rw_ex != REG_ZERO) &&
                ((use_rs_id && (rw_ex == rs_id)) || (use_rt_id && (rw_ex == rt_id)));

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        ctl           = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
        case (state)
            RUN: begin
                if (branch_taken_ex) begin
                    ctl = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
                end else if (lu) begin
                    // Halt (if also present) is re-evaluated once the load moves on.
                    ctl = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
                end else if (halt_id) begin
                    ctl           = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b0};
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = '0;
                end else if (jump_id) begin
                    ctl = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};
                end
            end
            DRAIN: begin
                // No branch can resolve here: halt was only accepted with EX branch-free.
                ctl           = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
                drain_cnt_nxt = drain_cnt + DW'(1);
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                ctl = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
            end
            default: begin
                ctl       = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Hold the pipeline frozen and bubbled for as long as reset is asserted.
    assign pc_en      = rst_n & ctl.pc_en;
    assign ifid_en    = rst_n & ctl.ifid_en;
    assign ifid_flush = ~rst_n | ctl.ifid_flush;
    assign idex_flush = ~rst_n | ctl.idex_flush;
    assign halted     = (state == HALTED);

`ifdef HAZARD_PERF_EN
    logic             stall_win, flush_win;
    logic [CNT_W-1:0] stall_q, flush_q, cycle_q;

    assign stall_win = (state == RUN) && !branch_taken_ex && lu;
    assign flush_win = (state == RUN) &&
                       (branch_taken_ex || (!lu && !halt_id && jump_id));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
            cycle_q <= '0;
        end else begin
            if (state != HALTED) cycle_q <= cycle_q + CNT_W'(1);
            if (stall_win)       stall_q <= stall_q + CNT_W'(1);
            if (flush_win)       flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
    assign cycle_cnt = cycle_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign cycle_cnt = '0;
`endif

endmodule
